// File: rtl/rs_pkg.sv
// Shared definitions for the reservation-station pair: station IDs, entry states, instruction layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rs_pkg;

  // Station IDs, one pair per functional-unit class. Zero is reserved for "operand ready".
  localparam logic [3:0] ADD_0   = 4'b0001;
  localparam logic [3:0] ADD_1   = 4'b0010;
  localparam logic [3:0] MUL_0   = 4'b0011;
  localparam logic [3:0] MUL_1   = 4'b0100;
  localparam logic [3:0] FETCH_0 = 4'b0101;
  localparam logic [3:0] FETCH_1 = 4'b0110;
  localparam logic [3:0] STORE_0 = 4'b0111;
  localparam logic [3:0] STORE_1 = 4'b1000;

  // A source tag of zero means the value travels with the instruction.
  localparam logic [3:0] TAG_RDY = 4'b0000;

  // Instruction is {rs_id, src0_tag, src1_tag}; offsets are in units of one field width.
  localparam int FLD_RS_ID = 2;
  localparam int FLD_SRC0  = 1;
  localparam int FLD_SRC1  = 0;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2,
    EXEC  = 2'd3
  } rs_state_e;

endpackage

// File: rtl/rs_entry.sv
// One reservation station: holds an op's source tags/values, snoops the CDB, and pulses done when freed.
// Latency: loaded at the dispatch edge; READY visible the next cycle; done one cycle after the completing CDB edge.
// Backpressure: stays READY until issue is asserted; never drops a loaded op.
module rs_entry
  import rs_pkg::*;
#(
  parameter int                 TAG_LEN  = 4,
  parameter int                 DATA_WID = 16,
  parameter logic [TAG_LEN-1:0] RS_ID    = TAG_LEN'(ADD_0)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [TAG_LEN-1:0]  ld_tag0,
  input  logic [TAG_LEN-1:0]  ld_tag1,
  input  logic [DATA_WID-1:0] ld_val0,
  input  logic [DATA_WID-1:0] ld_val1,
  input  logic                cdb_valid,
  input  logic [TAG_LEN-1:0]  cdb_tag,
  input  logic [DATA_WID-1:0] cdb_data,
  input  logic                issue,
  output rs_state_e           state,
  output logic [DATA_WID-1:0] op_a,
  output logic [DATA_WID-1:0] op_b,
  output logic                done
);

  localparam logic [TAG_LEN-1:0] TAG_NONE = TAG_LEN'(TAG_RDY);

  rs_state_e                     state_q, state_d;
  logic [1:0][TAG_LEN-1:0]       tag_q, tag_d;
  logic [1:0][DATA_WID-1:0]      val_q, val_d;
  logic                          done_q, done_d;
  logic [1:0][TAG_LEN-1:0]       ld_tag;
  logic [1:0][DATA_WID-1:0]      ld_val;

  assign ld_tag = {ld_tag1, ld_tag0};
  assign ld_val = {ld_val1, ld_val0};

  // Next-state: load with same-cycle CDB bypass, CDB capture while waiting, issue, completion.
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    val_d   = val_q;
    done_d  = 1'b0;
    unique case (state_q)
      FREE: begin
        if (load) begin
          for (int i = 0; i < 2; i++) begin
            if (ld_tag[i] == TAG_NONE) begin
              tag_d[i] = TAG_NONE;
              val_d[i] = ld_val[i];
            end else if (cdb_valid && (cdb_tag == ld_tag[i])) begin
              tag_d[i] = TAG_NONE;
              val_d[i] = cdb_data;
            end else begin
              tag_d[i] = ld_tag[i];
              val_d[i] = '0;
            end
          end
          state_d = ((tag_d[0] == TAG_NONE) && (tag_d[1] == TAG_NONE)) ? READY : WAIT;
        end
      end
      WAIT: begin
        for (int i = 0; i < 2; i++) begin
          if ((tag_q[i] != TAG_NONE) && cdb_valid && (cdb_tag == tag_q[i])) begin
            tag_d[i] = TAG_NONE;
            val_d[i] = cdb_data;
          end
        end
        if ((tag_d[0] == TAG_NONE) && (tag_d[1] == TAG_NONE)) begin
          state_d = READY;
        end
      end
      READY: begin
        if (issue) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Our own ID on the CDB is the FU's result for this station.
        if (cdb_valid && (cdb_tag == RS_ID)) begin
          state_d = FREE;
          done_d  = 1'b1;
        end
      end
      default: state_d = FREE;
    endcase
  end

  // Station registers; reset clears everything so stale CDB tags cannot complete anything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FREE;
      tag_q   <= '0;
      val_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      val_q   <= val_d;
      done_q  <= done_d;
    end
  end

  assign state = state_q;
  assign op_a  = val_q[0];
  assign op_b  = val_q[1];
  assign done  = done_q;

endmodule

// File: rtl/rs_pair.sv
// Reservation-station pair for one FU class: steers dual dispatch into two stations, arbitrates issue (entry 0 first).
// Latency: earliest fu_req the cycle after dispatch; done pulses the cycle after the completing CDB broadcast.
// Backpressure: fu_req and operands hold while fu_ready is low; dispatch to a busy station is dropped.
// Optional: RS_PAIR_ERR_CHECK_EN adds err_sticky, flagging dropped/colliding dispatches until reset.
module rs_pair
  import rs_pkg::*;
#(
  parameter int                 INS_PART_WID = 4,
  parameter int                 TAG_LEN      = 4,
  parameter int                 DATA_WID     = 16,
  parameter logic [TAG_LEN-1:0] RS_ID0       = TAG_LEN'(ADD_0),
  parameter logic [TAG_LEN-1:0] RS_ID1       = TAG_LEN'(ADD_1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3*INS_PART_WID-1:0] instruction1,
  input  logic                      instruction1_valid,
  input  logic [DATA_WID-1:0]       inst1_val0,
  input  logic [DATA_WID-1:0]       inst1_val1,
  input  logic [3*INS_PART_WID-1:0] instruction2,
  input  logic                      instruction2_valid,
  input  logic [DATA_WID-1:0]       inst2_val0,
  input  logic [DATA_WID-1:0]       inst2_val1,
  input  logic                      cdb_valid,
  input  logic [TAG_LEN-1:0]        cdb_tag,
  input  logic [DATA_WID-1:0]       cdb_data,
  output logic                      fu_req,
  input  logic                      fu_ready,
  output logic [TAG_LEN-1:0]        fu_tag,
  output logic [DATA_WID-1:0]       fu_op_a,
  output logic [DATA_WID-1:0]       fu_op_b,
  output logic [1:0]                done,
  output logic [1:0]                rs_busy
`ifdef RS_PAIR_ERR_CHECK_EN
  ,
  output logic                      err_sticky
`endif
);

  logic [INS_PART_WID-1:0] b1_id, b1_s0, b1_s1, b2_id, b2_s0, b2_s1;
  logic [1:0]              hit1, hit2, load, issue, free;
  logic [1:0][TAG_LEN-1:0]  ld_tag0, ld_tag1;
  logic [1:0][DATA_WID-1:0] ld_val0, ld_val1, op_a, op_b;
  rs_state_e               st0, st1;

  assign b1_id = instruction1[FLD_RS_ID*INS_PART_WID +: INS_PART_WID];
  assign b1_s0 = instruction1[FLD_SRC0*INS_PART_WID  +: INS_PART_WID];
  assign b1_s1 = instruction1[FLD_SRC1*INS_PART_WID  +: INS_PART_WID];
  assign b2_id = instruction2[FLD_RS_ID*INS_PART_WID +: INS_PART_WID];
  assign b2_s0 = instruction2[FLD_SRC0*INS_PART_WID  +: INS_PART_WID];
  assign b2_s1 = instruction2[FLD_SRC1*INS_PART_WID  +: INS_PART_WID];

  assign free = {st1 == FREE, st0 == FREE};

  // Dispatch steering: a station loads from bus 1 if addressed there, otherwise from bus 2, only when FREE.
  always_comb begin
    hit1    = '0;
    hit2    = '0;
    load    = '0;
    ld_tag0 = '0;
    ld_tag1 = '0;
    ld_val0 = '0;
    ld_val1 = '0;
    hit1[0] = instruction1_valid && (b1_id == RS_ID0);
    hit1[1] = instruction1_valid && (b1_id == RS_ID1);
    hit2[0] = instruction2_valid && (b2_id == RS_ID0);
    hit2[1] = instruction2_valid && (b2_id == RS_ID1);
    for (int k = 0; k < 2; k++) begin
      load[k] = free[k] && (hit1[k] || hit2[k]);
      if (hit1[k]) begin
        ld_tag0[k] = b1_s0;
        ld_tag1[k] = b1_s1;
        ld_val0[k] = inst1_val0;
        ld_val1[k] = inst1_val1;
      end else begin
        ld_tag0[k] = b2_s0;
        ld_tag1[k] = b2_s1;
        ld_val0[k] = inst2_val0;
        ld_val1[k] = inst2_val1;
      end
    end
  end

  // Issue arbitration: entry 0 wins; FU outputs come straight from station registers.
  always_comb begin
    issue   = '0;
    fu_req  = 1'b0;
    fu_tag  = '0;
    fu_op_a = '0;
    fu_op_b = '0;
    if (st0 == READY) begin
      fu_req   = 1'b1;
      fu_tag   = RS_ID0;
      fu_op_a  = op_a[0];
      fu_op_b  = op_b[0];
      issue[0] = fu_ready;
    end else if (st1 == READY) begin
      fu_req   = 1'b1;
      fu_tag   = RS_ID1;
      fu_op_a  = op_a[1];
      fu_op_b  = op_b[1];
      issue[1] = fu_ready;
    end
  end

  rs_entry #(
    .TAG_LEN (TAG_LEN),
    .DATA_WID(DATA_WID),
    .RS_ID   (RS_ID0)
  ) u_entry0 (
    .clk      (clk),
    .rst      (rst),
    .load     (load[0]),
    .ld_tag0  (ld_tag0[0]),
    .ld_tag1  (ld_tag1[0]),
    .ld_val0  (ld_val0[0]),
    .ld_val1  (ld_val1[0]),
    .cdb_valid(cdb_valid),
    .cdb_tag  (cdb_tag),
    .cdb_data (cdb_data),
    .issue    (issue[0]),
    .state    (st0),
    .op_a     (op_a[0]),
    .op_b     (op_b[0]),
    .done     (done[0])
  );

  rs_entry #(
    .TAG_LEN (TAG_LEN),
    .DATA_WID(DATA_WID),
    .RS_ID   (RS_ID1)
  ) u_entry1 (
    .clk      (clk),
    .rst      (rst),
    .load     (load[1]),
    .ld_tag0  (ld_tag0[1]),
    .ld_tag1  (ld_tag1[1]),
    .ld_val0  (ld_val0[1]),
    .ld_val1  (ld_val1[1]),
    .cdb_valid(cdb_valid),
    .cdb_tag  (cdb_tag),
    .cdb_data (cdb_data),
    .issue    (issue[1]),
    .state    (st1),
    .op_a     (op_a[1]),
    .op_b     (op_b[1]),
    .done     (done[1])
  );

  assign rs_busy = ~free;

`ifdef RS_PAIR_ERR_CHECK_EN
  logic err_q, err_d;

  // Sticky flag: dispatch into a busy station, or both buses colliding on one station.
  always_comb begin
    err_d = err_q;
    for (int k = 0; k < 2; k++) begin
      if (((hit1[k] || hit2[k]) && !free[k]) || (hit1[k] && hit2[k])) begin
        err_d = 1'b1;
      end
    end
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_sticky = err_q;
`endif

endmodule

// File: doc/rs_pair.md
Name: rs_pair

Overview:
- Receiving end of the dual instruction dispatch buses: one pair of reservation stations serving a single functional-unit class (adder, multiplier, fetch or store).
- Instantiated once per class, with RS_ID0/RS_ID1 set to that class's station IDs.
- Latches instructions addressed to its stations and captures operands from dispatch or from the common data bus (CDB).
- Issues ready operations to its functional unit and returns the per-station done pulses the dispatcher uses to free stations.

Parameters:
- INS_PART_WID, 4, width of each instruction field (rs id, src0, src1).
- TAG_LEN, 4, width of station/producer tags; must equal INS_PART_WID.
- DATA_WID, 16, operand/result width.
- RS_ID0, 4'b0001, station ID of entry 0 (nonzero).
- RS_ID1, 4'b0010, station ID of entry 1 (nonzero, != RS_ID0).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- instruction1  in  3*INS_PART_WID  dispatch bus 1 {rs_id, src0_tag, src1_tag}.
- instruction1_valid  in  1  bus 1 qualifier.
- inst1_val0, inst1_val1  in  DATA_WID each  register-file operand values for bus 1.
- instruction2  in  3*INS_PART_WID  dispatch bus 2, same format.
- instruction2_valid  in  1  bus 2 qualifier.
- inst2_val0, inst2_val1  in  DATA_WID each  operand values for bus 2.
- cdb_valid  in  1  result broadcast valid.
- cdb_tag  in  TAG_LEN  producing station ID.
- cdb_data  in  DATA_WID  result value.
- fu_req  out  1  operation offered to functional unit.
- fu_ready  in  1  functional unit accepts; transfer on fu_req && fu_ready.
- fu_tag  out  TAG_LEN  station ID of the offered op.
- fu_op_a, fu_op_b  out  DATA_WID each  operands.
- done  out  2  done[0]/done[1]: one-cycle pulse, station freed.
- rs_busy  out  2  entry not FREE.

Behaviour:
- Per-entry state: FREE -> WAIT -> READY -> EXEC -> FREE.
- Reset (async): all entries FREE, operand fields 0, fu_req=0, fu_tag=0, fu_op_a/b=0, done=0, rs_busy=0.
- Dispatch:
  - A valid bus whose rs_id equals an entry's ID, with that entry FREE, loads the entry at the edge.
  - For each source: tag 0 means ready, value taken from instN_valX. Nonzero tag means pending on that tag.
  - Entry goes to READY if both sources are ready, else WAIT.
  - Dispatch to a non-FREE entry is ignored.
  - Both buses naming the same entry: bus 1 wins, bus 2 ignored.
  - Both buses naming different entries: both load in the same cycle.
- CDB capture:
  - Every cycle, each pending source whose tag equals cdb_tag (cdb_valid=1) takes cdb_data and becomes ready.
  - A WAIT entry with both sources ready moves to READY at that edge.
  - Same-cycle bypass: a dispatched source tag matching the concurrent CDB broadcast is captured from cdb_data at load, never left pending.
- Issue:
  - fu_req=1 when any entry is READY; outputs are driven from entry registers, not from bus inputs.
  - Entry 0 has fixed priority when both are READY.
  - Earliest fu_req is the cycle after the dispatch edge.
  - On an fu_req && fu_ready edge, the offered entry goes to EXEC.
  - With fu_ready low, outputs hold stable.
- Completion:
  - cdb_valid with cdb_tag == ID of an EXEC entry moves it to FREE at the edge, and the matching done bit is high for the next cycle only.
  - A freed entry accepts a new dispatch in the cycle done is high.
  - A CDB tag matching a non-EXEC entry produces no done.
- Reset mid-operation: entries cleared immediately. Later CDB broadcasts of old tags find no EXEC entry and produce no done.

Optional Feature:
- RS_PAIR_ERR_CHECK_EN defined: adds output err_sticky (1 bit, reset 0).
  - Set on a valid dispatch to a non-FREE entry, or on both buses naming the same entry.
  - Stays set until rst.
- Not defined: no err_sticky port; such dispatches are silently ignored.

Decomposition:
- Shared package rs_pkg holds:
  - station ID constants ADD_0..STORE_1 (4'b0001..4'b1000);
  - entry state enum (FREE/WAIT/READY/EXEC);
  - instruction field offsets for rs_id/src0/src1;
  - tag value 0 = "operand ready".
- Natural sub-module: rs_entry (one station: state, tags, values, CDB capture/bypass, done pulse).
- rs_pair instantiates two rs_entry plus dispatch steering and issue arbitration.

Test Plan:
- Bus 1 = {0001,0000,0000} with vals 5/7, fu_ready=1 -> next cycle fu_req=1, fu_tag=0001, op_a=5, op_b=7. Following cycle entry EXEC; CDB tag 0001 -> done[0] pulses one cycle.
- Bus 1 src0 tag 0011 -> entry WAIT, no fu_req. CDB {0011, 0x00AA} -> fu_req next cycle with op_a=0x00AA.
- Dispatch src1 tag 0100 in the same cycle CDB broadcasts {0100, 0x1234} -> entry READY immediately, op_b=0x1234.
- Both buses to RS_ID0 and RS_ID1, both READY, fu_ready=1 -> fu_tag=0001 first, then 0010 the next cycle.
- Both buses to RS_ID0 -> only bus 1 loaded; err_sticky=1 when macro defined.
- rst asserted while entry 0 in EXEC -> all outputs 0 immediately. Subsequent CDB tag 0001 -> done stays 0.
